mont_conversion: RTL
====================

# mont_conversion

Converts a natural-number operand into Montgomery form, x_mont = (x · R) mod N with R = 2^WIDTH, using a bit-serial doubling-and-conditional-subtract loop. Sits directly upstream of mont_reduction and the Montgomery multiplier in the modular-exponentiation datapath: operands enter here once, are processed in Montgomery form, and leave through mont_reduction. Fixed latency, one conversion in flight, busy/valid handshake matching mont_reduction.

## Interface
- WIDTH, 512: operand width in bits; R is implicitly 2^WIDTH.
- clk_in  input  1  system clock; all state updates on the rising edge.
- rst_in  input  1  reset, asynchronous, active-low.
- x_in  input  WIDTH  natural-number operand; sampled only on the accepting edge.
- N  input  WIDTH  modulus; nonzero; sampled only on the accepting edge.
- valid_in  input  1  start request; single-cycle pulse or level.
- x_mont  output  WIDTH  result (x_in · 2^WIDTH) mod N; held until the next completion.
- valid_out  output  1  one-cycle pulse when x_mont is updated.
- busy_out  output  1  high while a conversion is in progress.

## Operation
- States: IDLE, PREP, SHIFT.
- IDLE: on valid_in = 1, capture x_in and N into internal registers, go to PREP, raise busy_out.
- PREP (1 cycle): r <= (x_reg >= N_reg) ? x_reg − N_reg : x_reg; clear step counter; go to SHIFT. The result is correct for any x_in < 2N; for x_in ≥ 2N the output value is unspecified, but latency and handshake are unchanged.
- SHIFT (WIDTH cycles): each step computes t = 2r in WIDTH+1 bits, compares t ≥ N_reg in WIDTH+1 bits, and sets r <= (t ≥ N_reg) ? t − N_reg : t. Invariant: r < N_reg, so r fits in WIDTH bits. The step counter is $clog2(WIDTH+1) bits wide and counts 0..WIDTH−1.
- On the edge that performs step WIDTH−1:
  - x_mont <= final r.
  - valid_out <= 1.
  - busy_out <= 0.
  - Return to IDLE.
- valid_in while busy_out = 1 is ignored; the request is not queued and the in-flight operands are not disturbed.
- valid_in during the cycle in which valid_out = 1: the block is in IDLE, so the request is accepted (back-to-back operation).
- Input changes after the accepting edge have no effect on the in-flight result.
- N = 0: result unspecified. The block must still complete in fixed latency and must not hang.

## Timing
- Reset (rst_in = 0, asynchronous): state IDLE, x_mont = 0, valid_out = 0, busy_out = 0, counter and r cleared. Reset mid-conversion aborts it and no valid_out is produced. The first valid_in is honoured on the first rising edge after rst_in deasserts.
- Accepting edge E0 (IDLE, valid_in = 1): busy_out = 1 from after E0.
- PREP runs on E1; SHIFT steps run on E2..E(WIDTH+1).
- After E(WIDTH+1): valid_out = 1, busy_out = 0, x_mont valid. Latency is WIDTH+1 cycles from the accepting edge (17 for WIDTH = 16, 513 for WIDTH = 512).
- valid_out lasts exactly one cycle. busy_out and valid_out are never high together.
- Throughput: one conversion every WIDTH+1 cycles.

## Test plan
- WIDTH=16, N=33227, x_in=46, single-cycle valid_in -> valid_out exactly 17 cycles after the accepting edge, x_mont=24226; busy_out high for those 17 cycles.
- WIDTH=16, N=33227: x_in=0 -> x_mont=0; x_in=33226 -> 918; x_in=33232 (≥N, PREP path) -> 28637.
- WIDTH=16, N=33227: x_in=46 accepted, then valid_in=1 with x_in=7 pulsed at cycles 3 and 10 -> the second request is ignored and x_mont=24226. Then x_in=1 with valid_in held high through the valid_out cycle -> accepted back-to-back, x_mont=32309 exactly 17 cycles later.
- Reset mid-operation: assert rst_in low asynchronously (between edges) at cycle 8 of a conversion -> outputs zero immediately; no valid_out appears. After release, x_in=46 -> 24226 with normal latency.
- WIDTH=512 round trip:
  - N = 8446001084112110468007350899866059366449315229085619820000217473402760874334633786644317357840696578249028889585050688594982676710791149734896799707926013.
  - x_in = 82289494155958622552101842259948196324913095467108646453504357986875686437490.
  - x_mont must equal (x_in · 2^512) mod N, computed by the bench.
  - Feeding x_mont into mont_reduction, with the matching N_prime, must return the original x_in.

Source files
------------

// File: rtl/mont_conversion.sv
// mont_conversion: converts x into Montgomery form (x * 2^WIDTH) mod N by bit-serial doubling
// with conditional subtraction; fixed WIDTH+1 cycle latency, one conversion in flight.
module mont_conversion #(
    parameter int WIDTH = 512
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic [WIDTH-1:0] x_in,
    input  logic [WIDTH-1:0] N,
    input  logic             valid_in,
    output logic [WIDTH-1:0] x_mont,
    output logic             valid_out,
    output logic             busy_out
);
    localparam int CW = $clog2(WIDTH + 1);
    typedef enum logic [1:0] {IDLE, PREP, SHIFT} state_t;
    state_t           r_state;
    logic [WIDTH-1:0] r_x;
    logic [WIDTH-1:0] r_n;
    logic [WIDTH-1:0] r_acc;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH:0]   w_dbl;
    logic             w_dbl_ge;
    logic [WIDTH-1:0] w_step;
    logic [WIDTH-1:0] w_prep;
    // with r < N the difference 2r - N fits in WIDTH bits, so the subtract can drop the top bit
    assign w_dbl    = {r_acc, 1'b0};
    assign w_dbl_ge = w_dbl >= {1'b0, r_n};
    assign w_step   = w_dbl_ge ? w_dbl[WIDTH-1:0] - r_n : w_dbl[WIDTH-1:0];
    assign w_prep   = (r_x >= r_n) ? r_x - r_n : r_x;
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state   <= IDLE;
            r_x       <= '0;
            r_n       <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            x_mont    <= '0;
            valid_out <= 1'b0;
            busy_out  <= 1'b0;
        end else begin
            valid_out <= 1'b0;
            case (r_state)
                IDLE: if (valid_in) begin
                    r_x      <= x_in;
                    r_n      <= N;
                    busy_out <= 1'b1;
                    r_state  <= PREP;
                end
                PREP: begin
                    r_acc   <= w_prep;
                    r_cnt   <= '0;
                    r_state <= SHIFT;
                end
                SHIFT: begin
                    r_acc <= w_step;
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == CW'(WIDTH - 1)) begin
                        x_mont    <= w_step;
                        valid_out <= 1'b1;
                        busy_out  <= 1'b0;
                        r_state   <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
